// File: rtl/prog_fetch_pkg.sv
// Shared constants for the instruction fetch block: FSM encoding and
// program memory geometry.
package prog_fetch_pkg;

  localparam int PM_DEPTH = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/prog_fetch_if.sv
// Bus between the control unit / program loader (master) and the fetch
// block (slave).
interface prog_fetch_if;
  import prog_fetch_pkg::*;

  logic [ADDR_W-1:0] pc_fetch;
  logic              stall_fetch;
  logic              load_en;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              mm_wr;
  logic [ADDR_W-1:0] mm_addr;
  logic [DATA_W-1:0] mm_wdata;
  logic [DATA_W-1:0] instr_fetch;
  logic              instr_valid;
  logic [1:0]        state_fetch;

  modport master (
    output pc_fetch, stall_fetch, load_en, load_valid, load_data,
           mm_wr, mm_addr, mm_wdata,
    input  load_ready, load_done, instr_fetch, instr_valid, state_fetch
  );

  modport slave (
    input  pc_fetch, stall_fetch, load_en, load_valid, load_data,
           mm_wr, mm_addr, mm_wdata,
    output load_ready, load_done, instr_fetch, instr_valid, state_fetch
  );

endinterface

// File: rtl/prog_fetch_mem.sv
// 16x8 flop program memory: one write port, asynchronous read with
// write-first bypass so a same-cycle write is visible on the read port.
module prog_mem
  import prog_fetch_pkg::*;
(
  input  logic              clk_mem,
  input  logic              rst_mem_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [PM_DEPTH-1:0][DATA_W-1:0] w_words;

  genvar gi;
  generate
    for (gi = 0; gi < PM_DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] r_word;

      always_ff @(posedge clk_mem or negedge rst_mem_n) begin
        if (!rst_mem_n)
          r_word <= '0;
        else if (i_we && (i_waddr == ADDR_W'(gi)))
          r_word <= i_wdata;
      end

      assign w_words[gi] = r_word;
    end
  endgenerate

  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : w_words[i_raddr];

endmodule

// File: rtl/prog_fetch.sv
// Instruction fetch: IDLE/LOAD/RUN control, byte-stream program loader and
// the registered instruction presented to the control unit.
module prog_fetch
  import prog_fetch_pkg::*;
(
  input  logic         clk_fetch,
  input  logic         rst_fetch,
  prog_fetch_if.slave  bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;

  logic              w_accept;
  logic              w_last;
  logic              w_mm_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // Loader and run-time writes never coincide: they are gated by different states.
  assign w_accept = (r_state == ST_LOAD) && bus.load_valid;
  assign w_last   = w_accept && (r_ptr == ADDR_W'(PM_DEPTH - 1));
  assign w_mm_we  = (r_state == ST_RUN) && bus.mm_wr;
  assign w_we     = w_accept || w_mm_we;
  assign w_waddr  = w_accept ? r_ptr : bus.mm_addr;
  assign w_wdata  = w_accept ? bus.load_data : bus.mm_wdata;

  prog_mem u_mem (
    .clk_mem   (clk_fetch),
    .rst_mem_n (rst_fetch),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr   (bus.pc_fetch),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk_fetch or negedge rst_fetch) begin
    if (!rst_fetch) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ptr <= '0;
          if (bus.load_en)
            r_state <= ST_LOAD;
          else
            r_state <= ST_RUN;
        end
        ST_LOAD: begin
          if (w_accept)
            r_ptr <= r_ptr + 1'b1;
          if (w_last)
            r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.load_en) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
          end else if (!bus.stall_fetch) begin
            r_instr <= w_rdata;
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= '0;
          r_instr <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.load_ready  = (r_state == ST_LOAD);
  assign bus.load_done   = w_last;
  assign bus.instr_fetch = r_instr;
  assign bus.instr_valid = r_valid;
  assign bus.state_fetch = r_state;

endmodule

// File: tb/tb_prog_fetch.sv
// Scoreboard bench for prog_fetch: a PM model predicts each fetched
// instruction, which is queued at drive time and checked on the next edge.
module tb_prog_fetch;
  import prog_fetch_pkg::*;

  logic clk_fetch = 1'b0;
  logic rst_fetch = 1'b0;

  prog_fetch_if bus ();

  prog_fetch dut (
    .clk_fetch (clk_fetch),
    .rst_fetch (rst_fetch),
    .bus       (bus)
  );

  always #5 clk_fetch = ~clk_fetch;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] pm_model [16];
  logic [7:0] exp_q [$];
  logic [7:0] exp_instr;
  logic       exp_valid;
  logic [7:0] img_a [16];
  logic [7:0] img_b [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.pc_fetch    = '0;
    bus.stall_fetch = 1'b1;
    bus.load_en     = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.mm_wr       = 1'b0;
    bus.mm_addr     = '0;
    bus.mm_wdata    = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, 32'(bus.state_fetch), 32'(ST_IDLE));
    check_val({tag, "_instr"}, 32'(bus.instr_fetch), 32'h0);
    check_val({tag, "_valid"}, 32'(bus.instr_valid), 32'h0);
    check_val({tag, "_ready"}, 32'(bus.load_ready), 32'h0);
    check_val({tag, "_done"},  32'(bus.load_done), 32'h0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) pm_model[i] = 8'h00;
    exp_instr = 8'h00;
    exp_valid = 1'b0;
  endtask

  // One RUN-state cycle; lv drives a stray load_valid that must be ignored.
  task automatic run_cycle(input logic [3:0] pc, input logic stall, input logic wr,
                           input logic [3:0] addr, input logic [7:0] wd, input logic lv);
    @(negedge clk_fetch);
    bus.pc_fetch    = pc;
    bus.stall_fetch = stall;
    bus.load_en     = 1'b0;
    bus.mm_wr       = wr;
    bus.mm_addr     = addr;
    bus.mm_wdata    = wd;
    bus.load_valid  = lv;
    bus.load_data   = 8'hEE;
    if (!stall) exp_q.push_back((wr && addr == pc) ? wd : pm_model[pc]);
    if (wr) pm_model[addr] = wd;
    @(posedge clk_fetch);
    #1;
    if (!stall) begin
      exp_instr = exp_q.pop_front();
      exp_valid = 1'b1;
    end
    check_val("run_instr", 32'(bus.instr_fetch), 32'(exp_instr));
    check_val("run_valid", 32'(bus.instr_valid), 32'(exp_valid));
    check_val("run_ready", 32'(bus.load_ready), 32'h0);
    check_val("run_state", 32'(bus.state_fetch), 32'(ST_RUN));
    $display("txn run pc=%0d stall=%0b wr=%0b instr=%02h", pc, stall, wr, bus.instr_fetch);
  endtask

  task automatic load_program(input logic [7:0] img [16], input bit gaps);
    int g;
    @(negedge clk_fetch);
    idle_inputs();
    bus.load_en = 1'b1;
    @(posedge clk_fetch);
    #1;
    exp_instr = 8'h00;
    exp_valid = 1'b0;
    check_val("enter_state", 32'(bus.state_fetch), 32'(ST_LOAD));
    check_val("enter_ready", 32'(bus.load_ready), 32'h1);
    check_val("enter_instr", 32'(bus.instr_fetch), 32'h0);
    check_val("enter_valid", 32'(bus.instr_valid), 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        g = $urandom_range(1, 3);
        repeat (g) begin
          @(negedge clk_fetch);
          bus.load_valid = 1'b0;
          bus.load_en    = (i == 5);
          bus.mm_wr      = 1'b1;
          bus.mm_addr    = 4'(i);
          bus.mm_wdata   = 8'hFF;
          #1;
          check_val("gap_done", 32'(bus.load_done), 32'h0);
          @(posedge clk_fetch);
          #1;
          check_val("gap_state", 32'(bus.state_fetch), 32'(ST_LOAD));
        end
      end
      @(negedge clk_fetch);
      bus.load_en    = (i == 9);
      bus.mm_wr      = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = img[i];
      #1;
      check_val("load_done", 32'(bus.load_done), (i == 15) ? 32'h1 : 32'h0);
      @(posedge clk_fetch);
      #1;
      pm_model[i] = img[i];
      check_val("load_state", 32'(bus.state_fetch), (i == 15) ? 32'(ST_RUN) : 32'(ST_LOAD));
      $display("txn load idx=%0d data=%02h", i, img[i]);
    end
    @(negedge clk_fetch);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    clear_model();
    for (int i = 0; i < 16; i++) begin
      img_a[i] = 8'(i * 8'h13 + 8'h07);
      img_b[i] = 8'(8'hC3 ^ (i * 8'h29));
    end
    img_a[0] = 8'h50;
    img_a[1] = 8'h00;
    img_a[2] = 8'h20;

    #12;
    check_reset_outputs("por");
    @(negedge clk_fetch);
    rst_fetch = 1'b1;
    @(posedge clk_fetch);
    #1;
    check_val("boot_state", 32'(bus.state_fetch), 32'(ST_RUN));
    check_val("boot_valid", 32'(bus.instr_valid), 32'h0);
    run_cycle(4'd5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    load_program(img_a, 1'b0);
    run_cycle(4'd2, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    for (int a = 0; a < 16; a++)
      run_cycle(4'(a), 1'b0, 1'b0, 4'd0, 8'h00, 1'(a % 2));

    load_program(img_b, 1'b1);
    for (int a = 0; a < 16; a++)
      run_cycle(4'(a), 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    run_cycle(4'd7, 1'b0, 1'b1, 4'd7, 8'hA5, 1'b0);
    run_cycle(4'd7, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    run_cycle(4'd3, 1'b0, 1'b1, 4'd9, 8'h3C, 1'b0);
    run_cycle(4'd9, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    run_cycle(4'd3, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    run_cycle(4'd3, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    run_cycle(4'd4, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    run_cycle(4'd5, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    run_cycle(4'd5, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    // Partial load interrupted by reset: memory must come back empty.
    @(negedge clk_fetch);
    idle_inputs();
    bus.load_en = 1'b1;
    @(posedge clk_fetch);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_fetch);
      bus.load_en    = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h80 | 8'(i);
      @(posedge clk_fetch);
    end
    @(negedge clk_fetch);
    bus.load_valid = 1'b0;
    rst_fetch = 1'b0;
    #1;
    check_reset_outputs("midload_rst");
    clear_model();
    @(negedge clk_fetch);
    rst_fetch = 1'b1;
    @(posedge clk_fetch);
    #1;
    check_val("reboot_state", 32'(bus.state_fetch), 32'(ST_RUN));
    for (int a = 0; a < 16; a++)
      run_cycle(4'(a), 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_fetch.md
PROG_FETCH -- requirements
Module: prog_fetch

Interface
REQ-001 clk_fetch  in  1  single clock; all state updates on rising edge.
REQ-002 rst_fetch  in  1  asynchronous, active-low reset; asserted clears all state immediately, released synchronously to clk_fetch.
REQ-003 pc_fetch  in  4  program counter from the control unit; selects the fetch address.
REQ-004 stall_fetch  in  1  high: hold the current instruction and instr_valid.
REQ-005 load_en  in  1  request entry to program-load mode.
REQ-006 load_valid  in  1  load_data carries a byte this cycle.
REQ-007 load_data  in  8  program byte to store at the load pointer.
REQ-008 load_ready  out  1  high in LOAD state; a byte is accepted when load_valid && load_ready.
REQ-009 load_done  out  1  one-cycle pulse when the 16th byte is accepted.
REQ-010 mm_wr  in  1  run-time memory write strobe from the control unit.
REQ-011 mm_addr  in  4  run-time write address.
REQ-012 mm_wdata  in  8  run-time write data (control-unit output bus).
REQ-013 instr_fetch  out  8  registered instruction feeding the control unit.
REQ-014 instr_valid  out  1  instr_fetch holds a fetched instruction.
REQ-015 state_fetch  out  2  current FSM state: IDLE=0, LOAD=1, RUN=2.

Function
REQ-016 Program memory SHALL be 16 x 8 flops, all cleared to 0x00 on reset.
REQ-017 FSM SHALL have states IDLE, LOAD and RUN; reset state is IDLE.
REQ-018 Transitions SHALL be: IDLE->LOAD on load_en; IDLE->RUN on the first cycle with load_en low; LOAD->RUN on the cycle after load_done; RUN->LOAD on load_en.
REQ-019 Entering LOAD SHALL clear the 4-bit load pointer to 0 and drop instr_valid.
REQ-020 Each accepted load byte SHALL be written to PM[pointer], and the pointer SHALL increment mod 16.
REQ-021 load_done SHALL pulse in the cycle the byte at pointer 15 is accepted; the pointer then wraps to 0.
REQ-022 load_valid outside LOAD SHALL be ignored; load_ready SHALL be low outside LOAD.
REQ-023 In RUN, with stall_fetch low, instr_fetch SHALL load PM[pc_fetch] every cycle (1-cycle latency from pc_fetch to instr_fetch), and instr_valid SHALL be set.
REQ-024 In RUN, with stall_fetch high, instr_fetch and instr_valid SHALL hold.
REQ-025 mm_wr SHALL write mm_wdata to PM[mm_addr] in RUN only; it is ignored in IDLE and LOAD.
REQ-026 On a write-to-read collision (mm_wr, mm_addr==pc_fetch, not stalled), instr_fetch SHALL capture mm_wdata (write-first bypass).
REQ-027 In IDLE and LOAD, instr_fetch SHALL be 0x00 and instr_valid SHALL be 0.
REQ-028 load_en asserted while already in LOAD SHALL have no effect and SHALL not restart the pointer.

Reset
REQ-029 On rst_fetch low, outputs SHALL be: instr_fetch=0x00, instr_valid=0, load_ready=0, load_done=0, state_fetch=IDLE; the load pointer and all PM words SHALL be 0.
REQ-030 Reset asserted mid-LOAD SHALL discard the partial load; after release, behaviour SHALL match a cold start.

Structure
REQ-031 A shared package SHALL hold the state encoding constants, PM depth (16), address width (4) and data width (8).
REQ-032 The 16x8 memory, with its write port and bypass read, SHALL be one sub-module, prog_mem; the FSM, load pointer and instruction register SHALL stay in prog_fetch.

Verification
REQ-033 Reset release with load_en=0 -> state RUN next cycle; pc_fetch=5 -> instr_fetch=0x00, instr_valid=1 one cycle later.
REQ-034 load_en, then 16 bytes 0x50,0x00,0x20,... with load_valid every cycle -> load_done on the 16th byte, RUN next cycle; pc_fetch=2 -> instr_fetch=0x20.
REQ-035 Load with load_valid gaps of 1-3 cycles -> the same memory image as the contiguous load; load_done only on the 16th accepted byte.
REQ-036 RUN, mm_wr=1, mm_addr=pc_fetch=7, mm_wdata=0xA5 -> instr_fetch=0xA5 next cycle, and PM[7]=0xA5 afterwards.
REQ-037 stall_fetch high for 3 cycles while pc_fetch changes 3->4->5 -> instr_fetch holds PM[3]; after release it shows PM[5].
REQ-038 rst_fetch pulsed low after the 8th load byte -> all outputs reset immediately; subsequent reads of PM[0..7] return 0x00.
